conv_feeder: RTL and testbench

Single-clock feeder that holds one input feature map (IFM) and the complete weight set for one conv+pool layer. Feeds both to the convolution-pooling engine through that engine's read-strobe interface: `ifm_read` and `wgt_read` come in, `ifm` and `wgt` go out. A host loads both buffers through a simple valid/ready port. The feeder then pulses `start_conv`, serves reads until the engine reports `end_pool`, and keeps the buffers so the same layer can be run again.

---
 rtl/conv_feeder_pkg.sv | 30 +++
 rtl/conv_feeder_buf.sv | 97 +++++++++
 rtl/conv_feeder.sv | 119 +++++++++++
 tb/tb_conv_feeder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_feeder_pkg.sv
// Shared types, helper functions and default geometry for the conv_feeder
// IFM/weight buffer feeding the convolution-pooling engine.
package conv_feeder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READY  = 2'd1,
      ST_ARM    = 2'd2,
      ST_STREAM = 2'd3
   } state_e;

   function automatic int max_f(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // A one-entry buffer still needs a 1-bit index.
   function automatic int ptr_w_f(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int IFM_WIDTH_DEF    = 16;
   localparam int WEIGHT_WIDTH_DEF = 16;
   localparam int IFM_DEPTH_DEF    = 27 * 27 * 3;
   localparam int WGT_DEPTH_DEF    = 5 * 5 * 3 * 8;

   localparam int LOAD_W    = max_f(IFM_WIDTH_DEF, WEIGHT_WIDTH_DEF);
   localparam int IFM_PTR_W = ptr_w_f(IFM_DEPTH_DEF);
   localparam int WGT_PTR_W = ptr_w_f(WGT_DEPTH_DEF);

endpackage

// File: rtl/conv_feeder_buf.sv
// One feeder buffer: sequential host fill, show-ahead read register and an
// end-of-buffer policy (wrap to 0, or stop with a sticky overrun flag).
module feeder_buf
   import conv_feeder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter bit WRAP  = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             flush_i,
   output logic             full_o,
   output logic             full_d_o,
   input  logic             arm_i,
   input  logic             rd_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             overrun_o
);

   localparam int PW = ptr_w_f(DEPTH);
   localparam int FW = ptr_w_f(DEPTH + 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [FW-1:0]    fill_q, fill_d;
   logic [PW-1:0]    ptr_q, ptr_d, ptr_nxt;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ovr_q, ovr_d;
   logic             wr_ok;

   assign full_o    = (fill_q == FILL_MAX);
   assign wr_ok     = wr_en_i && !flush_i && !full_o;
   assign full_d_o  = (fill_d == FILL_MAX);
   assign ptr_nxt   = ptr_q + PW'(1);
   assign rd_data_o = data_q;
   assign overrun_o = ovr_q;

   always_comb begin
      fill_d = fill_q;
      if (flush_i) begin
         fill_d = '0;
      end else if (wr_ok) begin
         fill_d = fill_q + FW'(1);
      end
   end

   // The output register always holds mem[ptr], so a read strobe can sample
   // the data in the same cycle and the next word appears one cycle later.
   always_comb begin
      ptr_d  = ptr_q;
      data_d = data_q;
      ovr_d  = ovr_q;
      if (arm_i) begin
         ptr_d  = '0;
         data_d = mem_q[0];
         ovr_d  = 1'b0;
      end else if (rd_i) begin
         if (ptr_q == PTR_LAST) begin
            if (WRAP) begin
               ptr_d  = '0;
               data_d = mem_q[0];
            end else begin
               ovr_d  = 1'b1;
               data_d = '0;
            end
         end else begin
            ptr_d  = ptr_nxt;
            data_d = mem_q[ptr_nxt];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         mem_q[fill_q[PW-1:0]] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fill_q <= '0;
         ptr_q  <= '0;
         data_q <= '0;
         ovr_q  <= 1'b0;
      end else begin
         fill_q <= fill_d;
         ptr_q  <= ptr_d;
         data_q <= data_d;
         ovr_q  <= ovr_d;
      end
   end

endmodule

// File: rtl/conv_feeder.sv
// Holds one IFM and one weight set, loaded by a host, and streams them to the
// conv-pool engine on its read strobes; the layer can be replayed without reload.
module conv_feeder
   import conv_feeder_pkg::*;
#(
   parameter int IFM_WIDTH    = 16,
   parameter int WEIGHT_WIDTH = 16,
   parameter int IFM_SIZE     = 27,
   parameter int KERNEL_SIZE  = 5,
   parameter int CI           = 3,
   parameter int CO           = 8,
   parameter int IFM_DEPTH    = IFM_SIZE * IFM_SIZE * CI,
   parameter int WGT_DEPTH    = KERNEL_SIZE * KERNEL_SIZE * CI * CO,
   parameter int LOAD_WIDTH   = max_f(IFM_WIDTH, WEIGHT_WIDTH)
) (
   input  logic                    clk1,
   input  logic                    rst,
   input  logic                    load_valid,
   input  logic                    load_sel,
   input  logic [LOAD_WIDTH-1:0]   load_data,
   output logic                    load_ready,
   input  logic                    flush,
   input  logic                    start,
   output logic                    start_conv,
   input  logic                    ifm_read,
   input  logic                    wgt_read,
   input  logic                    end_pool,
   output logic [IFM_WIDTH-1:0]    ifm,
   output logic [WEIGHT_WIDTH-1:0] wgt,
   output logic                    busy,
   output logic                    done,
   output logic                    overrun
);

   state_e state_q, state_d;
   logic   ifm_full, wgt_full, ifm_full_d, wgt_full_d;
   logic   ifm_rdy_q, ifm_rdy_d, wgt_rdy_q, wgt_rdy_d;
   logic   start_conv_q, done_q;
   logic   host_ok, host_ok_d, flush_eff, ifm_wr, wgt_wr, arm, stream;
   logic   ifm_ovr, wgt_ovr;

   assign host_ok    = (state_q == ST_IDLE) || (state_q == ST_READY);
   assign host_ok_d  = (state_d == ST_IDLE) || (state_d == ST_READY);
   assign flush_eff  = flush && host_ok;
   assign stream     = (state_q == ST_STREAM);
   assign arm        = (state_d == ST_ARM);
   assign load_ready = load_sel ? wgt_rdy_q : ifm_rdy_q;
   assign ifm_wr     = load_valid && load_ready && !load_sel;
   assign wgt_wr     = load_valid && load_ready && load_sel;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (ifm_full_d && wgt_full_d) state_d = ST_READY;
         ST_READY: begin
            if (flush)      state_d = ST_IDLE;
            else if (start) state_d = ST_ARM;
         end
         ST_ARM:    state_d = ST_STREAM;
         ST_STREAM: if (end_pool) state_d = ST_READY;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Readiness is registered from next-cycle state, so it is 0 out of reset.
   assign ifm_rdy_d = host_ok_d && !ifm_full_d;
   assign wgt_rdy_d = host_ok_d && !wgt_full_d;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ifm_rdy_q    <= 1'b0;
         wgt_rdy_q    <= 1'b0;
         start_conv_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ifm_rdy_q    <= ifm_rdy_d;
         wgt_rdy_q    <= wgt_rdy_d;
         start_conv_q <= arm;
         done_q       <= stream && end_pool;
      end
   end

   feeder_buf #(.WIDTH(IFM_WIDTH), .DEPTH(IFM_DEPTH), .WRAP(1'b0)) u_ifm_buf (
      .clk_i     (clk1),
      .rst_i     (rst),
      .wr_en_i   (ifm_wr),
      .wr_data_i (load_data[IFM_WIDTH-1:0]),
      .flush_i   (flush_eff),
      .full_o    (ifm_full),
      .full_d_o  (ifm_full_d),
      .arm_i     (arm),
      .rd_i      (stream && ifm_read),
      .rd_data_o (ifm),
      .overrun_o (ifm_ovr)
   );

   feeder_buf #(.WIDTH(WEIGHT_WIDTH), .DEPTH(WGT_DEPTH), .WRAP(1'b1)) u_wgt_buf (
      .clk_i     (clk1),
      .rst_i     (rst),
      .wr_en_i   (wgt_wr),
      .wr_data_i (load_data[WEIGHT_WIDTH-1:0]),
      .flush_i   (flush_eff),
      .full_o    (wgt_full),
      .full_d_o  (wgt_full_d),
      .arm_i     (arm),
      .rd_i      (stream && wgt_read),
      .rd_data_o (wgt),
      .overrun_o (wgt_ovr)
   );

   // The weight buffer wraps, so its flag never rises; only the IFM can overrun.
   assign overrun    = ifm_ovr | wgt_ovr;
   assign start_conv = start_conv_q;
   assign done       = done_q;
   assign busy       = (state_q == ST_ARM) || stream;

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder on a 4x4x1 IFM with one 2x2 kernel.
module tb_conv_feeder;

   logic        clk1 = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic        load_sel = 1'b0;
   logic [15:0] load_data = '0;
   logic        load_ready;
   logic        flush = 1'b0;
   logic        start = 1'b0;
   logic        start_conv;
   logic        ifm_read = 1'b0;
   logic        wgt_read = 1'b0;
   logic        end_pool = 1'b0;
   logic [15:0] ifm;
   logic [15:0] wgt;
   logic        busy;
   logic        done;
   logic        overrun;

   int n_cmp = 0;
   int n_bad = 0;

   conv_feeder #(
      .IFM_WIDTH(16), .WEIGHT_WIDTH(16), .IFM_SIZE(4), .KERNEL_SIZE(2), .CI(1), .CO(1)
   ) dut (
      .clk1       (clk1),
      .rst        (rst),
      .load_valid (load_valid),
      .load_sel   (load_sel),
      .load_data  (load_data),
      .load_ready (load_ready),
      .flush      (flush),
      .start      (start),
      .start_conv (start_conv),
      .ifm_read   (ifm_read),
      .wgt_read   (wgt_read),
      .end_pool   (end_pool),
      .ifm        (ifm),
      .wgt        (wgt),
      .busy       (busy),
      .done       (done),
      .overrun    (overrun)
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic load_word(input logic sel, input logic [15:0] d);
      int k;
      load_sel   = sel;
      load_data  = d;
      load_valid = 1'b1;
      #1;
      k = 0;
      while (!load_ready && k < 10) begin
         tick();
         k++;
      end
      if (!load_ready) chk("load_timeout", 32'(load_ready), 32'd1);
      else tick();
      load_valid = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_load_ready"}, 32'(load_ready), 32'd0);
      chk({tag, "_start_conv"}, 32'(start_conv), 32'd0);
      chk({tag, "_ifm"},        32'(ifm),        32'd0);
      chk({tag, "_wgt"},        32'(wgt),        32'd0);
      chk({tag, "_busy"},       32'(busy),       32'd0);
      chk({tag, "_done"},       32'(done),       32'd0);
      chk({tag, "_overrun"},    32'(overrun),    32'd0);
   endtask

   initial begin
      tick();
      tick();
      check_idle_outputs("rst");
      rst = 1'b0;
      tick();

      // Fill the IFM buffer 1..16, then try a 17th word that must be refused.
      for (int i = 0; i < 16; i++) load_word(1'b0, 16'(i + 1));
      load_sel = 1'b0;
      #1;
      chk("ifm_full_ready", 32'(load_ready), 32'd0);
      load_sel = 1'b1;
      #1;
      chk("wgt_empty_ready", 32'(load_ready), 32'd1);
      load_sel = 1'b0; load_data = 16'd99; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_idle_ignored", 32'(start_conv), 32'd0);
      tick();
      chk("start_idle_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 4; i++) load_word(1'b1, 16'(101 + i));
      chk("ready_wgt_ready", 32'(load_ready), 32'd0);
      load_sel = 1'b0;
      #1;
      chk("ready_ifm_ready", 32'(load_ready), 32'd0);

      // First run.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("arm_start_conv", 32'(start_conv), 32'd1);
      chk("arm_ifm", 32'(ifm), 32'd1);
      chk("arm_wgt", 32'(wgt), 32'd101);
      chk("arm_busy", 32'(busy), 32'd1);
      tick();
      chk("stream_start_conv", 32'(start_conv), 32'd0);
      chk("stream_busy", 32'(busy), 32'd1);

      ifm_read = 1'b1;
      wgt_read = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("ifm_seq", 32'(ifm), 32'(i + 1));
         chk("ifm_ovr_low", 32'(overrun), 32'd0);
         if (i < 9) chk("wgt_seq", 32'(wgt), 32'(101 + (i % 4)));
         tick();
         if (i == 8) wgt_read = 1'b0;
      end
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_ifm_zero", 32'(ifm), 32'd0);
      chk("wgt_hold", 32'(wgt), 32'd102);
      tick();
      ifm_read = 1'b0;
      chk("ovr_17_set", 32'(overrun), 32'd1);
      chk("ovr_17_ifm", 32'(ifm), 32'd0);

      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_stream_ignored", 32'(start_conv), 32'd0);
      chk("start_stream_ifm", 32'(ifm), 32'd0);

      end_pool = 1'b1;
      tick();
      end_pool = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_load_ready", 32'(load_ready), 32'd0);
      tick();
      chk("done_clear", 32'(done), 32'd0);

      // Replay without reloading.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("replay_start_conv", 32'(start_conv), 32'd1);
      chk("replay_ifm", 32'(ifm), 32'd1);
      chk("replay_wgt", 32'(wgt), 32'd101);
      chk("replay_ovr_clr", 32'(overrun), 32'd0);
      tick();
      ifm_read = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("replay_ifm6", 32'(ifm), 32'd6);

      // Reset mid-stream.
      rst = 1'b1;
      #1;
      check_idle_outputs("rst_async");
      tick();
      ifm_read = 1'b0;
      check_idle_outputs("rst_mid");
      rst = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_after_rst", 32'(start_conv), 32'd0);
      chk("busy_after_rst", 32'(busy), 32'd0);

      // Partial load, then flush together with a word that must be dropped.
      for (int i = 0; i < 3; i++) load_word(1'b0, 16'(77 + i));
      load_sel = 1'b0; load_data = 16'd55; load_valid = 1'b1; flush = 1'b1;
      tick();
      load_valid = 1'b0; flush = 1'b0;
      for (int i = 0; i < 16; i++) load_word(1'b0, 16'(201 + i));
      for (int i = 0; i < 4; i++) load_word(1'b1, 16'(301 + i));

      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run3_start_conv", 32'(start_conv), 32'd1);
      chk("run3_ifm", 32'(ifm), 32'd201);
      chk("run3_wgt", 32'(wgt), 32'd301);
      tick();
      ifm_read = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      ifm_read = 1'b0;
      chk("run3_ifm_last", 32'(ifm), 32'd216);
      chk("run3_ovr", 32'(overrun), 32'd0);

      // A flush while streaming must not drop the buffers or leave STREAM.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_stream_busy", 32'(busy), 32'd1);
      end_pool = 1'b1;
      tick();
      end_pool = 1'b0;
      chk("run3_done", 32'(done), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run4_start_conv", 32'(start_conv), 32'd1);
      chk("run4_ifm", 32'(ifm), 32'd201);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
